// File: rtl/pwm_ratio_gen.sv
// pwm_ratio_gen
//   Responder for the profiler's pwm_update / pwm_ratio / pwm_direction /
//   pwm_done handshake. It turns an 8-bit ratio into a 256-tick PWM waveform
//   and drives a direction pin. New values are taken into shadow registers
//   only at a period start, so a waveform never glitches mid-period.
//
//   Optional macro DIR_DEADTIME_EN: a direction reversal first holds pwm_out
//   low for DEADTIME_PERIODS whole periods before the new direction is driven.
//
// Parameters
//   CLK_DIV           clocks per PWM tick (>= 1); a period is 256 ticks
//   DEADTIME_PERIODS  forced-low periods on a reversal (DIR_DEADTIME_EN only)
//
// Ports
//   clock          in   main clock
//   reset_n        in   asynchronous active-low reset
//   pwm_enable     in   level; low idles the block with the output off
//   pwm_update     in   level; load ratio/direction at the next period start
//   pwm_ratio      in   [7:0] high time in ticks out of 256
//   pwm_direction  in   requested motor direction
//   pwm_done       out  rises once per period that ran on a freshly loaded ratio
//   pwm_out        out  PWM waveform, one clock behind the tick counter
//   pwm_dir_out    out  direction pin
//   period_strobe  out  high on the first clock of every period
//
// States
//   IDLE | disabled; counters and shadows held at zero
//   RUN  | normal PWM generation
//   DEAD | direction reversal pending; output forced low (DIR_DEADTIME_EN only)

module pwm_ratio_gen #(
    parameter int CLK_DIV          = 8,
    parameter int DEADTIME_PERIODS = 2
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       pwm_enable,
    input  logic       pwm_update,
    input  logic [7:0] pwm_ratio,
    input  logic       pwm_direction,
    output logic       pwm_done,
    output logic       pwm_out,
    output logic       pwm_dir_out,
    output logic       period_strobe
);
    localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(CLK_DIV - 1);

    if (CLK_DIV < 1 || DEADTIME_PERIODS < 1) begin : g_param_check
        $error("pwm_ratio_gen: CLK_DIV and DEADTIME_PERIODS must be >= 1");
    end

`ifdef DIR_DEADTIME_EN
    localparam int DW = (DEADTIME_PERIODS > 1) ? $clog2(DEADTIME_PERIODS) : 1;
    localparam logic [DW-1:0] DEAD_LOAD = DW'(DEADTIME_PERIODS - 1);
    typedef enum logic [1:0] {IDLE, RUN, DEAD} state_t;
    logic [DW-1:0] dead_cnt, dead_nx;
`else
    typedef enum logic {IDLE, RUN} state_t;
`endif

    state_t        state, state_nx;
    logic [PW-1:0] prescaler, prescaler_nx;
    logic [7:0]    tick_cnt, tick_nx;
    logic [7:0]    shadow_ratio, ratio_nx;
    logic          shadow_dir, dir_nx;
    logic          loaded, loaded_nx;
    logic          done_nx, out_nx, dir_out_nx;
    logic          period_start, period_end;

    assign period_start  = (tick_cnt == 8'd0)  && (prescaler == '0);
    assign period_end    = (tick_cnt == 8'hFF) && (prescaler == '0);
    // Counters sit at zero while reset or disabled; gate so the strobe stays low then.
    assign period_strobe = reset_n && pwm_enable && period_start;

    always_comb begin
        state_nx     = state;
        prescaler_nx = prescaler;
        tick_nx      = tick_cnt;
        ratio_nx     = shadow_ratio;
        dir_nx       = shadow_dir;
        loaded_nx    = loaded;
        done_nx      = pwm_done;
        dir_out_nx   = pwm_dir_out;
        out_nx       = 1'b0;
`ifdef DIR_DEADTIME_EN
        dead_nx      = dead_cnt;
`endif
        if (!pwm_enable) begin
            state_nx     = IDLE;
            prescaler_nx = '0;
            tick_nx      = '0;
            ratio_nx     = '0;
            dir_nx       = 1'b0;
            loaded_nx    = 1'b0;
            done_nx      = 1'b0;
`ifdef DIR_DEADTIME_EN
            dead_nx      = '0;
`endif
        end else begin
            if (prescaler == PRE_LAST) begin
                prescaler_nx = '0;
                tick_nx      = tick_cnt + 8'd1;
            end else begin
                prescaler_nx = prescaler + 1'b1;
            end

            if (state == IDLE)
                state_nx = RUN;

            if (period_end && loaded) begin
                done_nx   = 1'b1;
                loaded_nx = 1'b0;
            end

            if (period_start) begin
`ifdef DIR_DEADTIME_EN
                if (state == DEAD) begin
                    if (dead_cnt == '0) begin
                        // The pending direction is always the opposite of the shadow.
                        state_nx   = RUN;
                        ratio_nx   = pwm_ratio;
                        dir_nx     = ~shadow_dir;
                        dir_out_nx = ~shadow_dir;
                        loaded_nx  = 1'b1;
                        done_nx    = 1'b0;
                    end else begin
                        dead_nx = dead_cnt - 1'b1;
                    end
                end else if (pwm_update) begin
                    ratio_nx = pwm_ratio;
                    done_nx  = 1'b0;
                    if (pwm_direction != shadow_dir) begin
                        state_nx  = DEAD;
                        dead_nx   = DEAD_LOAD;
                        loaded_nx = 1'b0;
                    end else begin
                        dir_out_nx = pwm_direction;
                        loaded_nx  = 1'b1;
                    end
                end
`else
                if (pwm_update) begin
                    ratio_nx   = pwm_ratio;
                    dir_nx     = pwm_direction;
                    dir_out_nx = pwm_direction;
                    done_nx    = 1'b0;
                    loaded_nx  = 1'b1;
                end
`endif
            end

            // Compare against the ratio in force for this tick, including one
            // being loaded right now, so tick 0 of a new period is correct.
            out_nx = (tick_cnt < ratio_nx);
`ifdef DIR_DEADTIME_EN
            if (state_nx == DEAD)
                out_nx = 1'b0;
`endif
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            prescaler    <= '0;
            tick_cnt     <= '0;
            shadow_ratio <= '0;
            shadow_dir   <= 1'b0;
            loaded       <= 1'b0;
            pwm_done     <= 1'b0;
            pwm_out      <= 1'b0;
            pwm_dir_out  <= 1'b0;
`ifdef DIR_DEADTIME_EN
            dead_cnt     <= '0;
`endif
        end else begin
            state        <= state_nx;
            prescaler    <= prescaler_nx;
            tick_cnt     <= tick_nx;
            shadow_ratio <= ratio_nx;
            shadow_dir   <= dir_nx;
            loaded       <= loaded_nx;
            pwm_done     <= done_nx;
            pwm_out      <= out_nx;
            pwm_dir_out  <= dir_out_nx;
`ifdef DIR_DEADTIME_EN
            dead_cnt     <= dead_nx;
`endif
        end
    end

endmodule

// File: tb/tb_pwm_ratio_gen.sv
// Testbench for pwm_ratio_gen with CLK_DIV=1 (one period = 256 clocks).
// Stimulus pushes one expected record per period; the monitor pops it on each
// period_strobe and compares what it measured over the period just ended.

module tb_pwm_ratio_gen;
    logic       clock = 1'b0;
    logic       reset_n;
    logic       pwm_enable;
    logic       pwm_update;
    logic [7:0] pwm_ratio;
    logic       pwm_direction;
    logic       pwm_done;
    logic       pwm_out;
    logic       pwm_dir_out;
    logic       period_strobe;

    typedef struct {
        int   high;
        int   rises;
        logic lvl;
        logic dir;
    } exp_t;

    exp_t sb[$];
    exp_t e_cur;
    int   n_cmp    = 0;
    int   n_bad    = 0;
    int   hi_cnt   = 0;
    int   rise_cnt = 0;
    logic prev_done = 1'b0;
    logic en_q      = 1'b0;
    int   now_c     = 0;

    pwm_ratio_gen #(.CLK_DIV(1), .DEADTIME_PERIODS(2)) dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .pwm_enable    (pwm_enable),
        .pwm_update    (pwm_update),
        .pwm_ratio     (pwm_ratio),
        .pwm_direction (pwm_direction),
        .pwm_done      (pwm_done),
        .pwm_out       (pwm_out),
        .pwm_dir_out   (pwm_dir_out),
        .period_strobe (period_strobe)
    );

    always #5 clock = ~clock;

    always @(posedge clock) en_q <= pwm_enable;

    task automatic check(input string name, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    // Monitor: samples on the falling edge, away from the active edge.
    always @(negedge clock) begin
        if (!reset_n) begin
            check("reset_outputs",
                  int'({pwm_done, pwm_out, pwm_dir_out, period_strobe}), 0);
        end else begin
            if (!en_q)
                check("disabled_out_done", int'({pwm_out, pwm_done}), 0);
            if (!pwm_enable)
                check("disabled_strobe", int'(period_strobe), 0);
        end
        hi_cnt += int'(pwm_out);
        if (pwm_done && !prev_done)
            rise_cnt++;
        prev_done = pwm_done;
        if (period_strobe) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_strobe: got strobe, expected none (t=%0t)", $time);
            end else begin
                e_cur = sb.pop_front();
                check("high_clocks",   hi_cnt,              e_cur.high);
                check("done_rises",    rise_cnt,            e_cur.rises);
                check("done_at_start", int'(pwm_done),      int'(e_cur.lvl));
                check("dir_at_start",  int'(pwm_dir_out),   int'(e_cur.dir));
                check("out_at_start",  int'(pwm_out),       0);
            end
            hi_cnt   = 0;
            rise_cnt = 0;
        end
    end

    task automatic expect_period(input int h, input int r, input logic l, input logic d);
        exp_t x;
        x.high  = h;
        x.rises = r;
        x.lvl   = l;
        x.dir   = d;
        sb.push_back(x);
    endtask

    // Advance to 2 time units after the rising edge that starts cycle c.
    task automatic go(input int c);
        while (now_c < c) begin
            @(posedge clock);
            now_c++;
        end
        #2;
    endtask

    initial begin
        reset_n       = 1'b0;
        pwm_enable    = 1'b1;
        pwm_update    = 1'b1;
        pwm_ratio     = 8'd64;
        pwm_direction = 1'b0;
        expect_period(0, 0, 1'b0, 1'b0);              // window covering reset
        repeat (4) @(posedge clock);
        #2;
        reset_n = 1'b1;                               // cycle 0: first period start
        now_c   = 0;
        expect_period(64, 1, 1'b1, 1'b0);
        go(100);  pwm_ratio = 8'd0;                   // mid-period change ignored
        expect_period(0, 1, 1'b1, 1'b0);
        go(300);  pwm_ratio = 8'd255;
        expect_period(255, 1, 1'b1, 1'b0);
        go(600);  pwm_ratio = 8'd32;
        expect_period(32, 1, 1'b1, 1'b0);
        go(868);  pwm_ratio = 8'd200;                 // tick 100 of the ratio-32 period
        expect_period(200, 1, 1'b1, 1'b0);
        go(1100); pwm_ratio = 8'd90;
        expect_period(90, 1, 1'b1, 1'b0);
        go(1281); pwm_update = 1'b0;                  // single loaded period
        go(1600); pwm_ratio = 8'd5;                   // no update: shadow keeps 90
        expect_period(90, 0, 1'b1, 1'b0);
        go(1700); pwm_update = 1'b1; pwm_ratio = 8'd200;
        go(1920); pwm_enable = 1'b0;                  // tick 128
        expect_period(128, 0, 1'b0, 1'b0);
        go(1930); pwm_enable = 1'b1; pwm_ratio = 8'd10;
        expect_period(10, 1, 1'b1, 1'b0);
        go(2000); pwm_direction = 1'b1; pwm_ratio = 8'd100;
`ifdef DIR_DEADTIME_EN
        expect_period(0, 0, 1'b0, 1'b0);
        expect_period(0, 0, 1'b0, 1'b0);
        expect_period(100, 1, 1'b1, 1'b1);
`else
        expect_period(100, 1, 1'b1, 1'b1);
        expect_period(100, 1, 1'b1, 1'b1);
        expect_period(100, 1, 1'b1, 1'b1);
`endif
        go(3000); reset_n = 1'b0;                     // async reset mid-period
        go(3003); reset_n = 1'b1;
        expect_period(45, 0, 1'b0, 1'b0);
        go(3010);
        n_cmp++;
        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL missing_strobes: got %0d unconsumed records, expected 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, expected finish", $time);
        $fatal(1);
    end

endmodule
